// File: rtl/collide_ctrl.sv
// collide_ctrl -- game supervisor for the runner game.
//
// Watches the obstacle ("tree") and player ("dino") bounding boxes once per
// obstacle update, declares a collision after HIT_COUNT consecutive overlapping
// samples, and sequences the game through IDLE -> RESET -> RUN -> OVER.
// Optionally counts obstacles that the player has cleared.
//
// Optional feature: define COLLIDE_CTRL_SCORE_EN to build the pass detector and
// score counter. Without it, score is tied to zero.
//
// Parameters
//   HIT_COUNT      consecutive overlapping samples that make a hit (1..7)
//   RST_PULSE_LEN  game_rst width in clk_25MHz cycles (1..15)
//   SCREEN_W       tree_x at or beyond this is treated as off-screen
//
// Ports
//   clk_25MHz      sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   sample_tick    one-cycle strobe, once per obstacle update
//   start          level request to begin / restart a game
//   tree_*         obstacle position, extent and kind (kind 0 = none)
//   dino_*         player position and extent
//   game_rst       reset pulse to the obstacle and player blocks
//   stop           freeze level to the obstacle and player blocks
//   hit            one-cycle pulse when a collision is declared
//   state          IDLE=0, RESET=1, RUN=2, OVER=3
//   score          obstacles passed in the current game

module collide_ctrl #(
  parameter int HIT_COUNT     = 2,
  parameter int RST_PULSE_LEN = 4,
  parameter int SCREEN_W      = 640
) (
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic        sample_tick,
  input  logic        start,
  input  logic [9:0]  tree_x,
  input  logic [8:0]  tree_y,
  input  logic [9:0]  tree_size_x,
  input  logic [8:0]  tree_size_y,
  input  logic [3:0]  tree_state,
  input  logic [9:0]  dino_x,
  input  logic [8:0]  dino_y,
  input  logic [9:0]  dino_size_x,
  input  logic [8:0]  dino_size_y,
  output logic        game_rst,
  output logic        stop,
  output logic        hit,
  output logic [1:0]  state,
  output logic [15:0] score
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [10:0] SCREEN_W_L = 11'(SCREEN_W);
  localparam logic [2:0]  HIT_CNT_L  = 3'(HIT_COUNT);
  localparam logic [3:0]  PULSE_LAST = 4'(RST_PULSE_LEN - 1);

  state_t      state_q, state_nxt;
  logic [2:0]  hit_cnt_q, hit_cnt_nxt;
  logic [3:0]  pulse_cnt_q, pulse_cnt_nxt;
  logic        hit_q, hit_nxt;

  // Box edges are formed one bit wider than the coordinates so that an
  // object near the right/bottom limit cannot wrap around to a small value.
  logic [10:0] tree_x_end, dino_x_end;
  logic [9:0]  tree_y_end, dino_y_end;
  logic        obst_vld;
  logic        overlap;

  assign tree_x_end = {1'b0, tree_x} + {1'b0, tree_size_x};
  assign dino_x_end = {1'b0, dino_x} + {1'b0, dino_size_x};
  assign tree_y_end = {1'b0, tree_y} + {1'b0, tree_size_y};
  assign dino_y_end = {1'b0, dino_y} + {1'b0, dino_size_y};

  assign obst_vld = (tree_state != 4'd0) && (tree_size_y != 9'd0) &&
                    ({1'b0, tree_x} < SCREEN_W_L);

  assign overlap = obst_vld &&
                   ({1'b0, tree_x} < dino_x_end) && ({1'b0, dino_x} < tree_x_end) &&
                   ({1'b0, tree_y} < dino_y_end) && ({1'b0, dino_y} < tree_y_end);

  // Shared qualifiers used by both the FSM and the score path.
  logic       run_sample;
  logic       game_start;
  logic [2:0] hit_cnt_inc;
  logic       hit_now;

  assign run_sample  = (state_q == RUN) && sample_tick;
  assign game_start  = start && ((state_q == IDLE) || (state_q == OVER));
  assign hit_cnt_inc = hit_cnt_q + 3'd1;
  assign hit_now     = run_sample && overlap && (hit_cnt_inc == HIT_CNT_L);

  // State and control registers
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hit_cnt_q   <= 3'd0;
      pulse_cnt_q <= 4'd0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      hit_cnt_q   <= hit_cnt_nxt;
      pulse_cnt_q <= pulse_cnt_nxt;
      hit_q       <= hit_nxt;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_nxt     = state_q;
    hit_cnt_nxt   = hit_cnt_q;
    pulse_cnt_nxt = pulse_cnt_q;
    hit_nxt       = 1'b0;

    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_nxt     = RESET;
          hit_cnt_nxt   = 3'd0;
          pulse_cnt_nxt = 4'd0;
        end
      end

      RESET: begin
        // pulse_cnt counts the RESET cycles already spent; leave after the last.
        if (pulse_cnt_q == PULSE_LAST) begin
          state_nxt = RUN;
        end else begin
          pulse_cnt_nxt = pulse_cnt_q + 4'd1;
        end
      end

      RUN: begin
        if (sample_tick) begin
          if (overlap) begin
            hit_cnt_nxt = hit_cnt_inc;
            if (hit_now) begin
              hit_nxt   = 1'b1;
              state_nxt = OVER;
            end
          end else begin
            hit_cnt_nxt = 3'd0;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign state    = state_q;
  assign game_rst = (state_q == RESET);
  assign stop     = (state_q == OVER);
  assign hit      = hit_q;

`ifdef COLLIDE_CTRL_SCORE_EN
  // Pass detector: an obstacle counts once when its right edge first reaches
  // the player's left edge; the flag re-arms when the obstacle disappears or
  // a new obstacle appears at or to the right of the player.
  logic        passed_q;
  logic [15:0] score_q;
  logic        pass_geom;
  logic        pass_clr;

  assign pass_geom = obst_vld && (tree_x_end <= {1'b0, dino_x});
  assign pass_clr  = !obst_vld || (tree_x >= dino_x);

  // Score registers
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      passed_q <= 1'b0;
      score_q  <= 16'd0;
    end else if (game_start) begin
      score_q <= 16'd0;
    end else if (run_sample) begin
      if (pass_geom) begin
        passed_q <= 1'b1;
        // A hit on the same sample wins; score also saturates.
        if (!passed_q && !hit_now && (score_q != 16'hFFFF)) begin
          score_q <= score_q + 16'd1;
        end
      end else if (pass_clr) begin
        passed_q <= 1'b0;
      end
    end
  end

  assign score = score_q;
`else
  assign score = 16'd0;
`endif

endmodule
